// File: rtl/multi_dataflow_engine_ctrl_if.sv
// multi_dataflow_engine_ctrl_if: engine control inputs plus streamer/kernel handshakes gated by the engine
interface multi_dataflow_engine_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int CFG_W = 32
);
  logic             clear_i;
  logic             enable_i;
  logic             start_i;
  logic [CNT_W-1:0] cnt_limit_i;
  logic [CFG_W-1:0] configuration_i;
  logic             in_pel_valid_i;
  logic             in_pel_ready_o;
  logic             in_size_valid_i;
  logic             in_size_ready_o;
  logic             k_in_pel_valid_o;
  logic             k_in_pel_ready_i;
  logic             k_in_size_valid_o;
  logic             k_in_size_ready_i;
  logic             k_out_pel_valid_i;
  logic             k_out_pel_ready_o;
  logic             out_pel_valid_o;
  logic             out_pel_ready_i;
  logic             k_start_o;
  logic [CFG_W-1:0] k_configuration_o;
  logic             ready_o;
  logic             done_o;
  logic [CNT_W-1:0] cnt_out_pel_o;
  modport slave (
    input  clear_i, enable_i, start_i, cnt_limit_i, configuration_i,
           in_pel_valid_i, in_size_valid_i, k_in_pel_ready_i, k_in_size_ready_i,
           k_out_pel_valid_i, out_pel_ready_i,
    output in_pel_ready_o, in_size_ready_o, k_in_pel_valid_o, k_in_size_valid_o,
           k_out_pel_ready_o, out_pel_valid_o, k_start_o, k_configuration_o,
           ready_o, done_o, cnt_out_pel_o
  );
  modport master (
    output clear_i, enable_i, start_i, cnt_limit_i, configuration_i,
           in_pel_valid_i, in_size_valid_i, k_in_pel_ready_i, k_in_size_ready_i,
           k_out_pel_valid_i, out_pel_ready_i,
    input  in_pel_ready_o, in_size_ready_o, k_in_pel_valid_o, k_in_size_valid_o,
           k_out_pel_ready_o, out_pel_valid_o, k_start_o, k_configuration_o,
           ready_o, done_o, cnt_out_pel_o
  );
endinterface

// File: rtl/multi_dataflow_engine_ctrl.sv
// multi_dataflow_engine_ctrl: runs one job at a time, gating stream handshakes and counting output beats
module multi_dataflow_engine_ctrl #(
  parameter int CNT_W = 32,
  parameter int CFG_W = 32
) (
  input logic                         clk_i,
  input logic                         rst_i,
  multi_dataflow_engine_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, limit_q, limit_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic             k_start_q, k_start_d;
  logic             run_en, out_en, fire;
  // beats pass only while a job runs and is enabled; output also stops at the limit
  always_comb begin
    run_en                 = state_q == RUN && bus.enable_i;
    out_en                 = run_en && cnt_q < limit_q;
    bus.k_in_pel_valid_o   = run_en & bus.in_pel_valid_i;
    bus.in_pel_ready_o     = run_en & bus.k_in_pel_ready_i;
    bus.k_in_size_valid_o  = run_en & bus.in_size_valid_i;
    bus.in_size_ready_o    = run_en & bus.k_in_size_ready_i;
    bus.out_pel_valid_o    = out_en & bus.k_out_pel_valid_i;
    bus.k_out_pel_ready_o  = out_en & bus.out_pel_ready_i;
    fire                   = out_en & bus.k_out_pel_valid_i & bus.out_pel_ready_i;
    bus.ready_o            = state_q == IDLE;
    bus.done_o             = state_q == DONE;
    bus.cnt_out_pel_o      = cnt_q;
    bus.k_configuration_o  = cfg_q;
    bus.k_start_o          = k_start_q;
  end
  // job sequencing: clear overrides everything, accept latches the job, fires advance the count
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    limit_d   = limit_q;
    cfg_d     = cfg_q;
    k_start_d = 1'b0;
    if (bus.clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE && bus.start_i && bus.enable_i) begin
      cfg_d     = bus.configuration_i;
      limit_d   = bus.cnt_limit_i;
      cnt_d     = '0;
      k_start_d = 1'b1;
      state_d   = bus.cnt_limit_i == '0 ? DONE : RUN;
    end else if (fire) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_d == limit_q ? DONE : RUN;
    end
  end
  // state registers; the kernel start pulse lands with the freshly latched configuration
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      limit_q   <= '0;
      cfg_q     <= '0;
      k_start_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      limit_q   <= limit_d;
      cfg_q     <= cfg_d;
      k_start_q <= k_start_d;
    end
  end
endmodule
